// File: rtl/tag_debug_pkg.sv
// Shared definitions for the tag debug probe logic: scanner state encoding and
// the fixed probe slot assignments used at the tag top level.
package tag_debug_pkg;

    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } state_t;

    localparam int PRB_PACKET_COMPLETE = 0;
    localparam int PRB_CMD_COMPLETE    = 1;
    localparam int PRB_HANDLEMATCH     = 2;
    localparam int PRB_DOCRC           = 3;
    localparam int PRB_RX_EN           = 4;
    localparam int PRB_TX_EN           = 5;
    localparam int PRB_BITOUT          = 6;
    localparam int PRB_BITCLK          = 7;
    localparam int PRB_RNGBITIN        = 8;
    localparam int PRB_RX_OVERFLOW     = 9;
    localparam int PRB_TX_DONE         = 10;
    localparam int PRB_TXSETUPDONE     = 11;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronises an asynchronous strobe into clk and emits a one-cycle registered
// pulse per rising edge; high phases shorter than two clk periods are rejected.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic [STAGES-1:0] sync_q;
    logic              edge_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            edge_q <= sync_q[STAGES-1];
            // Requiring two consecutive high samples filters single-period glitches.
            pulse  <= sync_q[STAGES-1] & sync_q[STAGES-2] & ~edge_q;
        end
    end

endmodule

// File: rtl/debug_probe_scan.sv
// Serial debug probe scanner: shifts one probe bit out per external debug_clk
// edge, with freeze-frame snapshot, sticky capture and a frame-wrap marker.
module debug_probe_scan
    import tag_debug_pkg::*;
#(
    parameter int NUM_PROBES  = 16,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PROBES-1:0] probes,
    input  logic                  debug_clk,
    input  logic                  debug_latch,
    input  logic                  sticky_en,
    output logic                  debug_out,
    output logic [ADDR_W-1:0]     debug_addr,
    output logic                  debug_frame
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PROBES - 1);

    logic                  adv;
    logic                  wrap;
    state_t                state, state_n;
    logic [NUM_PROBES-1:0] snap, snap_n;
    logic [ADDR_W-1:0]     addr_n;
    logic                  out_n;
    logic                  frame_n;

    sync_edge_det #(
        .STAGES   (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk      (clk),
        .reset    (reset),
        .async_in (debug_clk),
        .pulse    (adv)
    );

    assign wrap = adv && (debug_addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LIVE;
            snap        <= '0;
            debug_addr  <= '0;
            debug_out   <= 1'b0;
            debug_frame <= 1'b0;
        end else begin
            state       <= state_n;
            snap        <= snap_n;
            debug_addr  <= addr_n;
            debug_out   <= out_n;
            debug_frame <= frame_n;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        snap_n  = snap;
        addr_n  = debug_addr;
        frame_n = 1'b0;

        // Explicit match keeps the select in range when 2^ADDR_W > NUM_PROBES.
        out_n = 1'b0;
        for (int i = 0; i < NUM_PROBES; i++) begin
            if (debug_addr == ADDR_W'(i)) out_n = snap[i];
        end

        case (state)
            LIVE: begin
                snap_n = sticky_en ? (snap | probes) : probes;
                if (debug_latch) begin
                    state_n = FROZEN;
                    addr_n  = '0;
                    snap_n  = snap;
                end else if (wrap) begin
                    addr_n  = '0;
                    frame_n = 1'b1;
                    snap_n  = probes;
                end else if (adv) begin
                    addr_n  = debug_addr + ADDR_W'(1);
                end
            end
            FROZEN: begin
                if (wrap) begin
                    state_n = LIVE;
                    addr_n  = '0;
                    frame_n = 1'b1;
                    snap_n  = probes;
                end else if (adv) begin
                    addr_n  = debug_addr + ADDR_W'(1);
                end
            end
            default: state_n = LIVE;
        endcase
    end

endmodule
